// File: rtl/z80_bus_cycle_gen.sv
// z80_bus_cycle_gen: Z80-style bus-cycle initiator.
// Converts a req/ack interface into registered memory, I/O, M1 opcode-fetch
// and refresh cycles on a Z80 bus, honoring WAIT_N and BUSRQ_N/BUSAK_N.
// All bus outputs come straight from flops; the FSM computes next values.
module z80_bus_cycle_gen #(
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        B_PHI,
  input  logic        RST_N,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [15:0] BA,
  output logic        BA_OE,
  output logic [7:0]  BD_OUT,
  output logic        BD_OE,
  input  logic [7:0]  BD_IN,
  output logic        BMREQ_N,
  output logic        BIORQ_N,
  output logic        BRD_N,
  output logic        N_BWR,
  output logic        BM1_N,
  output logic        BRFSH_N,
  input  logic        WAIT_N,
  input  logic        BUSRQ_N,
  output logic        BUSAK_N
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_GRANT
  } state_t;

  // All fields active-low; packed so the idle value is all ones.
  typedef struct packed {
    logic mreq;
    logic iorq;
    logic rd;
    logic wr;
    logic m1;
    logic rfsh;
  } strb_t;

  localparam strb_t      STRB_IDLE = '1;
  localparam logic [2:0] OP_MRD    = 3'b000;
  localparam logic [2:0] OP_MWR    = 3'b001;
  localparam logic [2:0] OP_M1     = 3'b010;
  localparam logic [2:0] OP_IORD   = 3'b011;
  localparam logic [2:0] OP_IOWR   = 3'b100;
  localparam logic [1:0] AUTO_W    = 2'(IO_AUTO_WAIT);

  state_t      state, state_nx;
  logic [2:0]  cur_op, op_nx;
  logic [1:0]  wcnt, wcnt_nx;
  logic [6:0]  r_q, r_nx;
  strb_t       strb, strb_nx;
  logic [15:0] ba_nx;
  logic [7:0]  bd_out_nx, rdata_nx;
  logic        ba_oe_nx, bd_oe_nx, busak_nx, ack_nx;

  logic op_ok, is_io, is_m1, is_rd, in_wr;

  assign op_ok = (op <= OP_IOWR);
  assign in_wr = (op == OP_MWR) || (op == OP_IOWR);
  assign is_io = (cur_op == OP_IORD) || (cur_op == OP_IOWR);
  assign is_m1 = (cur_op == OP_M1);
  assign is_rd = (cur_op == OP_MRD) || (cur_op == OP_IORD);

  assign BMREQ_N = strb.mreq;
  assign BIORQ_N = strb.iorq;
  assign BRD_N   = strb.rd;
  assign N_BWR   = strb.wr;
  assign BM1_N   = strb.m1;
  assign BRFSH_N = strb.rfsh;

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    state_nx  = state;
    op_nx     = cur_op;
    wcnt_nx   = wcnt;
    r_nx      = r_q;
    strb_nx   = strb;
    ba_nx     = BA;
    ba_oe_nx  = BA_OE;
    bd_out_nx = BD_OUT;
    bd_oe_nx  = BD_OE;
    busak_nx  = BUSAK_N;
    rdata_nx  = rdata;
    ack_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        // A DMA master outranks a waiting requester.
        if (!BUSRQ_N) begin
          state_nx = S_GRANT;
          busak_nx = 1'b0;
          ba_oe_nx = 1'b0;
        end else if (req && op_ok) begin
          state_nx = S_T1;
          op_nx    = op;
          ba_nx    = addr;
          wcnt_nx  = 2'd0;
          if (in_wr) begin
            bd_out_nx = wdata;
            bd_oe_nx  = 1'b1;
          end
        end
      end
      S_T1: begin
        state_nx = S_T2;
        case (cur_op)
          OP_MRD:  begin strb_nx.mreq = 1'b0; strb_nx.rd = 1'b0; end
          OP_MWR:  begin strb_nx.mreq = 1'b0; strb_nx.wr = 1'b0; end
          OP_M1:   begin strb_nx.mreq = 1'b0; strb_nx.rd = 1'b0; strb_nx.m1 = 1'b0; end
          OP_IORD: begin strb_nx.iorq = 1'b0; strb_nx.rd = 1'b0; end
          default: begin strb_nx.iorq = 1'b0; strb_nx.wr = 1'b0; end
        endcase
      end
      S_T2, S_TW: begin
        // I/O gets its forced waits first; WAIT_N is only looked at afterwards.
        if (is_io && (wcnt < AUTO_W)) begin
          state_nx = S_TW;
          wcnt_nx  = wcnt + 2'd1;
        end else if (!WAIT_N) begin
          state_nx = S_TW;
        end else if (is_m1) begin
          // Opcode is taken here; MREQ stays low straight into the refresh.
          state_nx     = S_T3;
          rdata_nx     = BD_IN;
          strb_nx.rd   = 1'b1;
          strb_nx.m1   = 1'b1;
          strb_nx.rfsh = 1'b0;
          ba_nx        = {9'b0, r_q};
        end else begin
          state_nx = S_T3;
        end
      end
      S_T3: begin
        if (is_m1) begin
          state_nx     = S_T4;
          strb_nx.mreq = 1'b1;
        end else begin
          state_nx = S_IDLE;
          ack_nx   = 1'b1;
          strb_nx  = STRB_IDLE;
          bd_oe_nx = 1'b0;
          if (is_rd) rdata_nx = BD_IN;
        end
      end
      S_T4: begin
        state_nx = S_IDLE;
        ack_nx   = 1'b1;
        strb_nx  = STRB_IDLE;
        r_nx     = r_q + 7'd1;
      end
      S_GRANT: begin
        if (BUSRQ_N) begin
          state_nx = S_IDLE;
          busak_nx = 1'b1;
          ba_oe_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        strb_nx  = STRB_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Registered bus outputs, latched op and refresh counter.
  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      cur_op  <= OP_MRD;
      wcnt    <= 2'd0;
      r_q     <= 7'd0;
      strb    <= STRB_IDLE;
      BA      <= 16'h0000;
      BA_OE   <= 1'b1;
      BD_OUT  <= 8'h00;
      BD_OE   <= 1'b0;
      BUSAK_N <= 1'b1;
      rdata   <= 8'h00;
      ack     <= 1'b0;
    end else begin
      cur_op  <= op_nx;
      wcnt    <= wcnt_nx;
      r_q     <= r_nx;
      strb    <= strb_nx;
      BA      <= ba_nx;
      BA_OE   <= ba_oe_nx;
      BD_OUT  <= bd_out_nx;
      BD_OE   <= bd_oe_nx;
      BUSAK_N <= busak_nx;
      rdata   <= rdata_nx;
      ack     <= ack_nx;
    end
  end

endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// Directed bench for z80_bus_cycle_gen (IO_AUTO_WAIT = 1).
module tb_z80_bus_cycle_gen;
  logic        B_PHI = 1'b0;
  logic        RST_N = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        ack;
  logic [7:0]  rdata;
  logic [15:0] BA;
  logic        BA_OE;
  logic [7:0]  BD_OUT;
  logic        BD_OE;
  logic [7:0]  BD_IN = 8'h00;
  logic        BMREQ_N, BIORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N;
  logic        WAIT_N = 1'b1;
  logic        BUSRQ_N = 1'b1;
  logic        BUSAK_N;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_cycle.
  int          o_ack, o_mreq, o_iorq, o_rd, o_wr, o_m1, o_rfsh, o_bdoe, o_bdbad;
  logic [15:0] o_ba_t1, o_ba_rf;
  logic [7:0]  o_rdata;

  z80_bus_cycle_gen #(.IO_AUTO_WAIT(1)) dut (
    .B_PHI(B_PHI), .RST_N(RST_N), .req(req), .op(op), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .BA(BA), .BA_OE(BA_OE),
    .BD_OUT(BD_OUT), .BD_OE(BD_OE), .BD_IN(BD_IN), .BMREQ_N(BMREQ_N),
    .BIORQ_N(BIORQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR), .BM1_N(BM1_N),
    .BRFSH_N(BRFSH_N), .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N)
  );

  always #5 B_PHI = ~B_PHI;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Issue one request and record what the bus does until ack (edge 0 = accept).
  // WAIT_N is low for edges [wstart, wstart+wlen).
  task automatic run_cycle(input logic [2:0] o, input logic [15:0] a,
                           input logic [7:0] wd, input int wstart, input int wlen);
    req = 1'b1; op = o; addr = a; wdata = wd; WAIT_N = 1'b1;
    o_ack = -1; o_mreq = 0; o_iorq = 0; o_rd = 0; o_wr = 0; o_m1 = 0;
    o_rfsh = 0; o_bdoe = 0; o_bdbad = 0; o_ba_t1 = 16'hxxxx; o_ba_rf = 16'hxxxx;
    o_rdata = 8'hxx;
    for (int n = 0; n < 24; n++) begin
      @(posedge B_PHI); #1;
      if (n == 0) o_ba_t1 = BA;
      if (!BMREQ_N) o_mreq++;
      if (!BIORQ_N) o_iorq++;
      if (!BRD_N)   o_rd++;
      if (!N_BWR)   o_wr++;
      if (!BM1_N)   o_m1++;
      if (!BRFSH_N) begin
        o_rfsh++;
        if (o_rfsh == 1) o_ba_rf = BA;
      end
      if (BD_OE) begin
        o_bdoe++;
        if (BD_OUT !== wd) o_bdbad++;
      end
      if (ack) begin
        o_ack = n; o_rdata = rdata; req = 1'b0;
        break;
      end
      WAIT_N = !(((n + 1) >= wstart) && ((n + 1) < wstart + wlen));
    end
    req = 1'b0; WAIT_N = 1'b1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(posedge B_PHI);
    #1;
    checks++;
    if ({BMREQ_N, BIORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N} !== 6'h3F) begin
      errors++; $display("FAIL reset_strobes got %b want 111111", {BMREQ_N, BIORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N});
    end
    checks++;
    if ({BUSAK_N, BA_OE, BD_OE, ack} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctrl got %b want 1100", {BUSAK_N, BA_OE, BD_OE, ack});
    end
    checks++;
    if ({BA, BD_OUT, rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h want 00000000", {BA, BD_OUT, rdata});
    end
    @(negedge B_PHI); RST_N = 1'b1;
    @(posedge B_PHI); #1;
  endtask

  task automatic test_mem_read;
    BD_IN = 8'hA5;
    run_cycle(3'b000, 16'h2000, 8'h00, 0, 0);
    checks++; if (o_ba_t1 !== 16'h2000) begin errors++; $display("FAIL mrd_ba got %h want 2000", o_ba_t1); end
    checks++; if (o_mreq !== 2) begin errors++; $display("FAIL mrd_mreq got %0d want 2", o_mreq); end
    checks++; if (o_rd !== 2) begin errors++; $display("FAIL mrd_rd got %0d want 2", o_rd); end
    checks++; if (o_iorq + o_wr + o_m1 + o_rfsh + o_bdoe !== 0) begin
      errors++; $display("FAIL mrd_other got %0d want 0", o_iorq + o_wr + o_m1 + o_rfsh + o_bdoe);
    end
    checks++; if (o_ack !== 3) begin errors++; $display("FAIL mrd_ack_edge got %0d want 3", o_ack); end
    checks++; if (o_rdata !== 8'hA5) begin errors++; $display("FAIL mrd_rdata got %h want a5", o_rdata); end
    @(posedge B_PHI); #1;
    checks++; if ({ack, BA} !== {1'b0, 16'h2000}) begin
      errors++; $display("FAIL mrd_after got ack=%b ba=%h want ack=0 ba=2000", ack, BA);
    end
  endtask

  task automatic test_mem_write;
    BD_IN = 8'hFF;
    run_cycle(3'b001, 16'h6000, 8'h3C, 2, 2);
    checks++; if (o_ba_t1 !== 16'h6000) begin errors++; $display("FAIL mwr_ba got %h want 6000", o_ba_t1); end
    checks++; if (o_wr !== 4) begin errors++; $display("FAIL mwr_wr got %0d want 4", o_wr); end
    checks++; if (o_mreq !== 4) begin errors++; $display("FAIL mwr_mreq got %0d want 4", o_mreq); end
    checks++; if (o_rd !== 0) begin errors++; $display("FAIL mwr_rd got %0d want 0", o_rd); end
    checks++; if (o_bdoe !== 5) begin errors++; $display("FAIL mwr_bdoe got %0d want 5", o_bdoe); end
    checks++; if (o_bdbad !== 0) begin errors++; $display("FAIL mwr_bdout got %0d bad want 0", o_bdbad); end
    checks++; if (o_ack !== 5) begin errors++; $display("FAIL mwr_ack_edge got %0d want 5", o_ack); end
  endtask

  task automatic test_io_read;
    BD_IN = 8'hC3;
    // WAIT_N low on the forced-wait edge is ignored; only the second low adds a cycle.
    run_cycle(3'b011, 16'h0012, 8'h00, 2, 2);
    checks++; if (o_iorq !== 4) begin errors++; $display("FAIL iord_iorq got %0d want 4", o_iorq); end
    checks++; if (o_rd !== 4) begin errors++; $display("FAIL iord_rd got %0d want 4", o_rd); end
    checks++; if (o_mreq !== 0) begin errors++; $display("FAIL iord_mreq got %0d want 0", o_mreq); end
    checks++; if (o_ack !== 5) begin errors++; $display("FAIL iord_ack_edge got %0d want 5", o_ack); end
    checks++; if (o_rdata !== 8'hC3) begin errors++; $display("FAIL iord_rdata got %h want c3", o_rdata); end
  endtask

  task automatic test_io_write;
    run_cycle(3'b100, 16'h00BF, 8'h5A, 0, 0);
    checks++; if (o_iorq !== 3) begin errors++; $display("FAIL iowr_iorq got %0d want 3", o_iorq); end
    checks++; if (o_wr !== 3) begin errors++; $display("FAIL iowr_wr got %0d want 3", o_wr); end
    checks++; if (o_mreq !== 0) begin errors++; $display("FAIL iowr_mreq got %0d want 0", o_mreq); end
    checks++; if (o_ack !== 4) begin errors++; $display("FAIL iowr_ack_edge got %0d want 4", o_ack); end
    checks++; if (o_bdbad !== 0 || o_bdoe !== 4) begin
      errors++; $display("FAIL iowr_bd got oe=%0d bad=%0d want oe=4 bad=0", o_bdoe, o_bdbad);
    end
  endtask

  task automatic test_invalid_op;
    int bad;
    bad = 0;
    req = 1'b1; op = 3'b111; addr = 16'hFFFF;
    repeat (6) begin
      @(posedge B_PHI); #1;
      if (ack || ({BMREQ_N, BIORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N} != 6'h3F)) bad++;
    end
    req = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL invalid_op got %0d active cycles want 0", bad); end
    checks++; if (BA !== 16'h00BF) begin errors++; $display("FAIL invalid_ba got %h want 00bf", BA); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 130; k++) begin
      logic [7:0]  d;
      logic [15:0] rf;
      d  = 8'(k) ^ 8'h5A;
      rf = 16'(k % 128);
      BD_IN = d;
      run_cycle(3'b010, 16'(16'h0100 + k), 8'h00, 0, 0);
      checks++; if (o_ba_rf !== rf) begin errors++; $display("FAIL m1_refresh[%0d] got %h want %h", k, o_ba_rf, rf); end
      checks++; if (o_rfsh !== 2) begin errors++; $display("FAIL m1_rfsh[%0d] got %0d want 2", k, o_rfsh); end
      checks++; if (o_m1 !== 1 || o_rd !== 1) begin
        errors++; $display("FAIL m1_m1rd[%0d] got m1=%0d rd=%0d want 1 1", k, o_m1, o_rd);
      end
      checks++; if (o_mreq !== 2) begin errors++; $display("FAIL m1_mreq[%0d] got %0d want 2", k, o_mreq); end
      checks++; if (o_ack !== 4) begin errors++; $display("FAIL m1_ack_edge[%0d] got %0d want 4", k, o_ack); end
      checks++; if (o_rdata !== d) begin errors++; $display("FAIL m1_rdata[%0d] got %h want %h", k, o_rdata, d); end
      checks++; if (o_ba_t1 !== 16'(16'h0100 + k)) begin
        errors++; $display("FAIL m1_ba[%0d] got %h want %h", k, o_ba_t1, 16'(16'h0100 + k));
      end
    end
  endtask

  task automatic test_bus_grant;
    int bad;
    int n_ack;
    BD_IN = 8'h77;
    req = 1'b1; op = 3'b000; addr = 16'h1234;
    @(posedge B_PHI); #1;            // T1
    @(posedge B_PHI); #1;            // T2
    BUSRQ_N = 1'b0;
    @(posedge B_PHI); #1;            // T3
    checks++; if (BUSAK_N !== 1'b1) begin errors++; $display("FAIL grant_midcycle got busak=%b want 1", BUSAK_N); end
    @(posedge B_PHI); #1;            // read ack
    checks++; if ({ack, BUSAK_N} !== 2'b11) begin errors++; $display("FAIL grant_read_ack got %b want 11", {ack, BUSAK_N}); end
    checks++; if (rdata !== 8'h77) begin errors++; $display("FAIL grant_rdata got %h want 77", rdata); end
    req = 1'b0;
    @(posedge B_PHI); #1;            // enter GRANT
    checks++; if ({BUSAK_N, BA_OE, ack} !== 3'b000) begin
      errors++; $display("FAIL grant_enter got %b want 000", {BUSAK_N, BA_OE, ack});
    end
    req = 1'b1; op = 3'b001; addr = 16'h5678; wdata = 8'h99;
    bad = 0;
    repeat (4) begin
      @(posedge B_PHI); #1;
      if (!N_BWR || !BMREQ_N || BD_OE || BUSAK_N || BA_OE) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL grant_hold got %0d bad cycles want 0", bad); end
    BUSRQ_N = 1'b1;
    @(posedge B_PHI); #1;            // release
    checks++; if ({BUSAK_N, BA_OE, BMREQ_N, N_BWR} !== 4'b1111) begin
      errors++; $display("FAIL grant_release got %b want 1111", {BUSAK_N, BA_OE, BMREQ_N, N_BWR});
    end
    @(posedge B_PHI); #1;            // write T1
    checks++; if ({BA, BD_OE, BD_OUT} !== {16'h5678, 1'b1, 8'h99}) begin
      errors++; $display("FAIL grant_write_t1 got ba=%h oe=%b d=%h want 5678 1 99", BA, BD_OE, BD_OUT);
    end
    n_ack = -1;
    for (int n = 1; n < 12; n++) begin
      @(posedge B_PHI); #1;
      if (ack) begin n_ack = n; req = 1'b0; break; end
    end
    req = 1'b0;
    checks++; if (n_ack !== 3) begin errors++; $display("FAIL grant_write_ack got %0d want 3", n_ack); end
  endtask

  task automatic test_reset_mid;
    int bad;
    BD_IN = 8'h11;
    req = 1'b1; op = 3'b000; addr = 16'h4321;
    @(posedge B_PHI); #1;
    @(posedge B_PHI); #1;            // T2
    checks++; if ({BMREQ_N, BRD_N} !== 2'b00) begin errors++; $display("FAIL rstmid_t2 got %b want 00", {BMREQ_N, BRD_N}); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({BMREQ_N, BRD_N, BA_OE, ack} !== 4'b1110 || BA !== 16'h0000) begin
      errors++; $display("FAIL rstmid_async got %b ba=%h want 1110 ba=0000", {BMREQ_N, BRD_N, BA_OE, ack}, BA);
    end
    req = 1'b0;
    bad = 0;
    repeat (2) begin @(posedge B_PHI); #1; if (ack) bad++; end
    @(negedge B_PHI); RST_N = 1'b1;
    repeat (3) begin
      @(posedge B_PHI); #1;
      if (ack || ({BMREQ_N, BIORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N} != 6'h3F)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles want 0", bad); end
    BD_IN = 8'h3C;
    run_cycle(3'b000, 16'h0042, 8'h00, 0, 0);
    checks++; if (o_ack !== 3 || o_rdata !== 8'h3C) begin
      errors++; $display("FAIL rstmid_read got ack=%0d rdata=%h want 3 3c", o_ack, o_rdata);
    end
    BD_IN = 8'h01;
    run_cycle(3'b010, 16'h0000, 8'h00, 0, 0);
    checks++; if (o_ba_rf !== 16'h0000) begin errors++; $display("FAIL rstmid_r got %h want 0000", o_ba_rf); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_read();
    test_io_write();
    test_invalid_op();
    test_back_to_back();
    test_bus_grant();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
